// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: PC/stage-register enables and flushes for load-use, branch/jump and dmem wait.
// Optional performance counters are enabled by defining PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        id_jump,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_cycles,
`endif
    output logic        mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;

    // ctl packing: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
    logic [6:0] run_ctl;
    logic [6:0] ctl;
    logic       load_use;
    logic       err_out;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // Unfrozen decision shared by RUN and the MEM_WAIT release cycle.
    always_comb begin
        run_ctl = 7'b11111_00;
        if (ex_branch_taken) begin
            run_ctl = 7'b11111_11;
        end else if (load_use) begin
            run_ctl = 7'b00111_01;
        end else if (id_jump) begin
            run_ctl = 7'b11111_10;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        ctl        = 7'b00000_00;
        err_out    = 1'b0;
        if (rst) begin
            ctl        = 7'b00000_11;
            state_d    = RUN;
            wait_cnt_d = 8'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 8'd1;
                    end else begin
                        ctl = run_ctl;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        if (wait_cnt_q == TIMEOUT_CNT) begin
                            state_d = ERR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 8'd1;
                        end
                    end else begin
                        ctl        = run_ctl;
                        state_d    = RUN;
                        wait_cnt_d = 8'd0;
                    end
                end
                ERR: begin
                    err_out = 1'b1;
                end
                default: begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} = ctl;
    assign mem_err = err_out;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_cycles_q, flush_cycles_d;

    // Saturating event counters; reset and ERR cycles are not counted as stalls.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cycles_d = flush_cycles_q;
        if (!rst && state_q != ERR && !pc_en && stall_cycles_q != 32'hFFFF_FFFF) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (!rst && if_id_flush && flush_cycles_q != 32'hFFFF_FFFF) begin
            flush_cycles_d = flush_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
            flush_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cycles = flush_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl (MEM_TIMEOUT=4): table-driven RUN vectors plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, ex_branch_taken, id_jump, dmem_req, dmem_ready;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, mem_err;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_cycles;
`endif

    int checks;
    int failures;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .id_jump         (id_jump),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles),
`endif
        .mem_err         (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output packing: {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id_flush, id_ex_flush, mem_err}
    localparam logic [7:0] O_RUN   = 8'b11111_00_0;
    localparam logic [7:0] O_STALL = 8'b00111_01_0;
    localparam logic [7:0] O_BR    = 8'b11111_11_0;
    localparam logic [7:0] O_JMP   = 8'b11111_10_0;
    localparam logic [7:0] O_FRZ   = 8'b00000_00_0;
    localparam logic [7:0] O_RST   = 8'b00000_11_0;
    localparam logic [7:0] O_ERR   = 8'b00000_00_1;

    typedef struct {
        string      name;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ert;
        logic       mr;
        logic       bt;
        logic       jmp;
        logic       req;
        logic       rdy;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ert,
                                 input logic mr, input logic bt, input logic jmp,
                                 input logic req, input logic rdy);
        @(negedge clk);
        id_rs           = rs;
        id_rt           = rt;
        ex_rt           = ert;
        ex_mem_read     = mr;
        ex_branch_taken = bt;
        id_jump         = jmp;
        dmem_req        = req;
        dmem_ready      = rdy;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_err};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic quiet();
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{"quiet",            5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
        vecs[1] = '{"loaduse_rs",       5'd5, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_STALL};
        vecs[2] = '{"loaduse_rt",       5'd3, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_STALL};
        vecs[3] = '{"loaduse_r0",       5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
        vecs[4] = '{"match_no_read",    5'd5, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, O_RUN};
        vecs[5] = '{"branch_over_lu",   5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, O_BR};
        vecs[6] = '{"jump_alone",       5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, O_JMP};
        vecs[7] = '{"lu_over_jump",     5'd7, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, O_STALL};
        vecs[8] = '{"branch_over_jump", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, O_BR};
        vecs[9] = '{"dmem_hit",         5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, O_RUN};

        rst = 1'b1;
        quiet();
        checkOutput("reset_c1", O_RST);
        quiet();
        checkOutput("reset_c2", O_RST);
        rst = 1'b0;
        quiet();
        checkOutput("reset_release", O_RUN);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].rs, vecs[i].rt, vecs[i].ert, vecs[i].mr,
                          vecs[i].bt, vecs[i].jmp, vecs[i].req, vecs[i].rdy);
            checkOutput(vecs[i].name, vecs[i].exp);
        end

        applyStimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("lu_single_stall", O_STALL);
        quiet();
        checkOutput("lu_next_proceeds", O_RUN);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("memwait_frz%0d", i), O_FRZ);
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_release", O_RUN);
        quiet();
        checkOutput("memwait_after", O_RUN);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("memwait_br_frz%0d", i), O_FRZ);
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_br_release", O_BR);

        applyStimulus(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("memwait_lu_frz", O_FRZ);
        applyStimulus(5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("memwait_lu_release", O_STALL);

        // Timeout: frozen for cycles 0..4 after the miss, ERR from cycle 5.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("timeout_wait%0d", i), O_FRZ);
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("timeout_err", O_ERR);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("err_sticky", O_ERR);
        rst = 1'b1;
        quiet();
        checkOutput("err_rst", O_RST);
        rst = 1'b0;
        quiet();
        checkOutput("err_rst_release", O_RUN);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        rst = 1'b1;
        quiet();
        rst = 1'b0;
        quiet();
        checkOutput("rst_midwait_run", O_RUN);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        checkOutput("rst_midwait_cnt_cleared", O_FRZ);
        rst = 1'b1;
        quiet();
        rst = 1'b0;

`ifdef PIPE_HAZARD_PERF_EN
        quiet();
        checkCount("perf_stall_reset", stall_cycles, 32'd0);
        checkCount("perf_flush_reset", flush_cycles, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        quiet();
        checkCount("perf_stall_cycles", stall_cycles, 32'd4);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        quiet();
        checkCount("perf_flush_cycles", flush_cycles, 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. Per cycle, it decides the enable and flush for the PC and each pipeline register. It handles load-use stalls, branch and jump squashes, and data-memory wait states, with a timeout into a sticky error state. It sits beside the main decoder and drives the stage-register enables in the top-level datapath.

## Interface
- MEM_TIMEOUT, 16: maximum stalled cycles per data-memory access before error (1..255).
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- ex_mem_read  in  1  MemRead of instruction in EX (ID/EX register).
- ex_rt  in  5  destination rt of instruction in EX.
- ex_branch_taken  in  1  beq in EX resolved taken.
- id_jump  in  1  Jump decoded for instruction in ID.
- dmem_req  in  1  MEM-stage instruction has MemRead or MemWrite.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  synchronous clear (bubble) of IF/ID, ID/EX.
- mem_err  out  1  memory timeout, sticky until rst.

## Operation
- States: RUN, MEM_WAIT, ERR (registered). Outputs are Mealy: combinational from state and inputs.
- rst high: state <= RUN, wait_cnt <= 0. During rst, all enables are 0, both flushes are 1, and mem_err is 0.
- The RUN evaluation uses this priority (highest first):
  1. Memory miss (dmem_req & !dmem_ready): all enables 0, no flush; state <= MEM_WAIT, wait_cnt <= 1.
  2. ex_branch_taken: all enables 1, if_id_flush=1, id_ex_flush=1 (PC loads target).
  3. Load-use (ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt)): pc_en=0, if_id_en=0, id_ex_flush=1, other enables 1.
  4. id_jump: all enables 1, if_id_flush=1.
  5. Otherwise: all enables 1, no flush.
- Branch overrides load-use because the stalled instruction is squashed. Load-use overrides jump; the jump is re-evaluated next cycle.
- MEM_WAIT behaviour:
  - dmem_ready=0: all enables 0, no flush. If wait_cnt==MEM_TIMEOUT, state <= ERR; else wait_cnt <= wait_cnt+1.
  - dmem_ready=1: outputs equal the RUN evaluation of the same inputs (rules 2-5); state <= RUN, wait_cnt <= 0.
  - Hazards present while frozen persist and resolve on the release cycle.
- ERR: all enables 0, no flush, mem_err=1. The state is left only by rst.
- wait_cnt is 8 bits and never exceeds MEM_TIMEOUT.

## Timing
- Load-use: exactly 1 bubble. The hazard cycle freezes PC/IF-ID; the next cycle proceeds if no new hazard.
- Branch/jump flush takes effect at the same clock edge as detection (0-cycle decision latency).
- Memory miss: the freeze begins in the cycle the miss is first seen. The pipeline advances in the first cycle dmem_ready=1.
- Timeout: with ready held low, state=ERR and mem_err=1 MEM_TIMEOUT+1 cycles after the miss first appears.
- A miss and a taken branch in the same cycle: the freeze wins; the branch flush is applied on the release cycle.
- rst mid-MEM_WAIT or in ERR: RUN on the next edge, counters cleared.

## Configuration
- PIPE_HAZARD_PERF_EN defined: adds output ports stall_cycles[31:0] and flush_cycles[31:0].
  - Both reset to 0.
  - stall_cycles increments each non-reset, non-ERR cycle with pc_en=0.
  - flush_cycles increments each non-reset cycle with if_id_flush=1.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: neither the ports nor the counter logic exist; all other behaviour is identical.

## Test plan
- Reset: hold rst 2 cycles -> all enables 0, flushes 1, mem_err 0. Release with quiet inputs -> all enables 1, no flush.
- Load-use: ex_mem_read=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle only. Same with ex_rt=0 -> no stall.
- Branch vs load-use: ex_branch_taken=1 together with a load-use match -> all enables 1, both flushes 1. id_jump alone -> only if_id_flush=1.
- Memory wait: dmem_req=1, dmem_ready low 3 cycles then high -> all enables 0 for 3 cycles, 1 on the 4th. Add ex_branch_taken=1 throughout -> flushes only on the 4th cycle.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, dmem_ready=0 forever -> mem_err=1 from cycle 5 after the miss, enables stay 0. Asserting rst -> mem_err=0 next cycle.
- Perf (PIPE_HAZARD_PERF_EN): 3-cycle memory wait plus one load-use -> stall_cycles=4. Two taken branches -> flush_cycles=2.
